// File: rtl/dab_pkg.sv
// dab_pkg: shared state encoding, bridge level constants, gate bit positions
// and the level-to-gate leg mapping used by dab_psm_modulator.
package dab_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;
  localparam logic signed [1:0] LVL_POS  = 2'sd1;
  localparam logic signed [1:0] LVL_ZERO = 2'sd0;
  localparam logic signed [1:0] LVL_NEG  = -2'sd1;
  localparam int G_AHI = 0;
  localparam int G_ALO = 1;
  localparam int G_BHI = 2;
  localparam int G_BLO = 3;
  // Zero freewheels through both low-side switches; disabled bridge is fully off.
  function automatic logic [3:0] leg_map(input logic en, input logic signed [1:0] v);
    logic [3:0] g;
    g        = '0;
    g[G_AHI] = en & (v == LVL_POS);
    g[G_ALO] = en & (v != LVL_POS);
    g[G_BHI] = en & (v == LVL_NEG);
    g[G_BLO] = en & (v != LVL_NEG);
    return g;
  endfunction
endpackage

// File: rtl/dab_leg_deadtime.sv
// dab_leg_deadtime: one half-bridge leg; turn-on of hi/lo is delayed by dt_cnt
// clocks after any request change, turn-off is immediate.
module dab_leg_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hi_req,
  input  logic            lo_req,
  input  logic [DT_W-1:0] dt_cnt,
  output logic            hi,
  output logic            lo
);
  logic            r_hi_req;
  logic            r_lo_req;
  logic [DT_W-1:0] r_cnt;
  logic            w_chg;
  logic            w_done;
  assign w_chg  = {hi_req, lo_req} != {r_hi_req, r_lo_req};
  // r_cnt holds clocks since the last change; the change cycle itself counts as 0.
  assign w_done = w_chg ? (dt_cnt == '0) : (r_cnt >= dt_cnt);
  assign hi     = hi_req & w_done;
  assign lo     = lo_req & w_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_req <= 1'b0;
      r_lo_req <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_hi_req <= hi_req;
      r_lo_req <= lo_req;
      r_cnt    <= w_chg ? DT_W'(1) : (&r_cnt ? r_cnt : r_cnt + DT_W'(1));
    end
  end
endmodule

// File: rtl/dab_psm_modulator.sv
// dab_psm_modulator: three-level phase-shift DAB modulator with double-buffered timing.
// Define DAB_DEADTIME_EN to insert per-leg turn-on dead time of dt_cnt clocks.
module dab_psm_modulator
  import dab_pkg::*;
#(
  parameter int CNT_W = 19,
  parameter int DT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    sync,
  input  logic [CNT_W-1:0]        hp_cnt,
  input  logic [CNT_W-1:0]        tau1_cnt,
  input  logic [CNT_W-1:0]        tau2_cnt,
  input  logic [CNT_W-1:0]        phi_cnt,
  input  logic [DT_W-1:0]         dt_cnt,
  output logic signed [1:0]       V1,
  output logic signed [1:0]       V2,
  output logic [3:0]              Sp,
  output logic [3:0]              Ss,
  output logic                    period_done,
  output logic                    busy
);
  localparam int W = CNT_W + 1;
  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_hp;
  logic [CNT_W-1:0]        r_tau1;
  logic [CNT_W-1:0]        r_tau2;
  logic [W-1:0]            r_cnt1;
  logic [W-1:0]            r_cnt2;
  logic signed [1:0]       r_v1;
  logic signed [1:0]       r_v2;
  logic                    r_en;
  logic                    w_busy;
  logic                    w_wrap;
  logic                    w_start;
  logic                    w_load;
  logic [W-1:0]            w_last;
  logic [CNT_W-1:0]        w_hp;
  logic [CNT_W-1:0]        w_tau1;
  logic [CNT_W-1:0]        w_tau2;
  logic signed [W:0]       w_phi_raw;
  logic signed [W:0]       w_pmax;
  logic signed [W:0]       w_phi;
  logic [W-1:0]            w_cnt2_init;
  logic [3:0]              w_sp_req;
  logic [3:0]              w_ss_req;

  function automatic logic signed [1:0] level(input logic [W-1:0] c,
                                              input logic [CNT_W-1:0] hp,
                                              input logic [CNT_W-1:0] tau);
    logic         h;
    logic [W-1:0] pos;
    h   = c >= {1'b0, hp};
    pos = h ? c - {1'b0, hp} : c;
    return (pos >= {1'b0, hp - tau}) ? (h ? LVL_NEG : LVL_POS) : LVL_ZERO;
  endfunction

  // Clamping is applied to the incoming values, always against the new hp.
  assign w_hp        = (hp_cnt < CNT_W'(2)) ? CNT_W'(2) : hp_cnt;
  assign w_tau1      = (tau1_cnt > w_hp) ? w_hp : tau1_cnt;
  assign w_tau2      = (tau2_cnt > w_hp) ? w_hp : tau2_cnt;
  assign w_phi_raw   = signed'({{2{phi_cnt[CNT_W-1]}}, phi_cnt});
  assign w_pmax      = signed'({2'b00, w_hp}) - (W+1)'(1);
  assign w_phi       = (w_phi_raw > w_pmax) ? w_pmax : ((w_phi_raw < -w_pmax) ? -w_pmax : w_phi_raw);
  assign w_cnt2_init = (w_phi > 0) ? {w_hp, 1'b0} - W'(w_phi) : W'(-w_phi);

  assign w_busy      = r_state != IDLE;
  assign w_last      = {r_hp, 1'b0} - W'(1);
  assign w_wrap      = w_busy & (r_cnt1 == w_last);
  assign w_start     = (r_state == IDLE) & run & sync;
  assign w_load      = w_start | w_wrap;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? ((run & sync) ? RUN : IDLE)
           : run ? RUN
           : ((r_state == STOPPING) & w_wrap) ? IDLE : STOPPING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hp   <= '0;
      r_tau1 <= '0;
      r_tau2 <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_v1   <= LVL_ZERO;
      r_v2   <= LVL_ZERO;
      r_en   <= 1'b0;
    end else begin
      if (w_load) begin
        r_hp   <= w_hp;
        r_tau1 <= w_tau1;
        r_tau2 <= w_tau2;
        r_cnt1 <= '0;
        r_cnt2 <= w_cnt2_init;
      end else if (w_busy) begin
        r_cnt1 <= r_cnt1 + W'(1);
        r_cnt2 <= (r_cnt2 == w_last) ? '0 : r_cnt2 + W'(1);
      end
      r_en <= w_busy;
      r_v1 <= w_busy ? level(r_cnt1, r_hp, r_tau1) : LVL_ZERO;
      r_v2 <= w_busy ? level(r_cnt2, r_hp, r_tau2) : LVL_ZERO;
    end
  end

  assign V1          = r_v1;
  assign V2          = r_v2;
  assign period_done = w_wrap;
  assign busy        = w_busy;
  assign w_sp_req    = leg_map(r_en, r_v1);
  assign w_ss_req    = leg_map(r_en, r_v2);

`ifdef DAB_DEADTIME_EN
  for (genvar i = 0; i < 2; i++) begin : g_leg
    dab_leg_deadtime #(.DT_W(DT_W)) u_p (
      .clk(clk), .rst(rst), .hi_req(w_sp_req[2*i]), .lo_req(w_sp_req[2*i+1]),
      .dt_cnt(dt_cnt), .hi(Sp[2*i]), .lo(Sp[2*i+1])
    );
    dab_leg_deadtime #(.DT_W(DT_W)) u_s (
      .clk(clk), .rst(rst), .hi_req(w_ss_req[2*i]), .lo_req(w_ss_req[2*i+1]),
      .dt_cnt(dt_cnt), .hi(Ss[2*i]), .lo(Ss[2*i+1])
    );
  end
`else
  logic w_unused_dt;
  assign w_unused_dt = ^dt_cnt;
  assign Sp          = w_sp_req;
  assign Ss          = w_ss_req;
`endif
endmodule

// File: tb/tb_dab_psm_modulator.sv
// tb_dab_psm_modulator: scoreboard bench; a period-position model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_dab_psm_modulator;
  localparam int CNT_W = 19;
  localparam int DT_W  = 8;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             sync = 1'b0;
  logic [CNT_W-1:0] hp_cnt = '0;
  logic [CNT_W-1:0] tau1_cnt = '0;
  logic [CNT_W-1:0] tau2_cnt = '0;
  logic [CNT_W-1:0] phi_cnt = '0;
  logic [DT_W-1:0]  dt_cnt = '0;
  logic [1:0]       V1;
  logic [1:0]       V2;
  logic [3:0]       Sp;
  logic [3:0]       Ss;
  logic             period_done;
  logic             busy;
  int               n_chk = 0;
  int               n_fail = 0;
  logic [13:0]      exp_q[$];
  bit               m_busy = 0;
  bit               m_stop = 0;
  int               m_t = 0;
  int               m_hp = 0;
  int               m_t1 = 0;
  int               m_t2 = 0;
  int               m_phi = 0;

  always #5 clk = ~clk;

  dab_psm_modulator #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .sync(sync), .hp_cnt(hp_cnt),
    .tau1_cnt(tau1_cnt), .tau2_cnt(tau2_cnt), .phi_cnt(phi_cnt), .dt_cnt(dt_cnt),
    .V1(V1), .V2(V2), .Sp(Sp), .Ss(Ss), .period_done(period_done), .busy(busy)
  );

  // Bridge level at position p of a 2*hp period: active for the last tau clocks of each half.
  function automatic int lvl(int p, int hp, int tau);
    int half;
    half = p / hp;
    return ((p % hp) >= hp - tau) ? (half == 0 ? 1 : -1) : 0;
  endfunction

  function automatic logic [1:0] enc(int v);
    return v == 1 ? 2'b01 : (v == -1 ? 2'b11 : 2'b00);
  endfunction

  function automatic logic [3:0] gates(bit on, int v);
    if (!on) return 4'b0000;
    return v == 1 ? 4'b1001 : (v == -1 ? 4'b0110 : 4'b1010);
  endfunction

  task automatic load();
    int p;
    m_hp  = int'(hp_cnt) < 2 ? 2 : int'(hp_cnt);
    m_t1  = int'(tau1_cnt) > m_hp ? m_hp : int'(tau1_cnt);
    m_t2  = int'(tau2_cnt) > m_hp ? m_hp : int'(tau2_cnt);
    p     = int'($signed(phi_cnt));
    m_phi = p > m_hp - 1 ? m_hp - 1 : (p < 1 - m_hp ? 1 - m_hp : p);
  endtask

  always @(posedge clk) begin
    int  v1, v2, per;
    bit  was_busy, pd;
    v1 = 0;
    v2 = 0;
    was_busy = m_busy;
    if (m_busy) begin
      per = 2 * m_hp;
      v1  = lvl(m_t, m_hp, m_t1);
      v2  = lvl(((m_t - m_phi) % per + per) % per, m_hp, m_t2);
    end
    if (rst) begin
      m_busy = 0; m_stop = 0; m_t = 0; v1 = 0; v2 = 0; was_busy = 0;
    end else begin
      if (!m_busy) begin
        if (run && sync) begin load(); m_busy = 1; m_t = 0; end
      end else if (m_t == 2 * m_hp - 1) begin
        m_t = 0;
        if (m_stop && !run) m_busy = 0;
        load();
      end else m_t++;
      m_stop = m_busy && !run;
    end
    pd = m_busy && (m_t == 2 * m_hp - 1);
    exp_q.push_back({enc(v1), enc(v2), gates(was_busy, v1), gates(was_busy, v2), pd, m_busy});
  end

  always @(posedge clk) begin
    logic [13:0] e, a;
    #1;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      a = {V1, V2, Sp, Ss, period_done, busy};
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs at %0t: actual V1V2=%b_%b Sp=%b Ss=%b pd=%b busy=%b, required V1V2=%b_%b Sp=%b Ss=%b pd=%b busy=%b",
                 $time, a[13:12], a[11:10], a[9:6], a[5:2], a[1], a[0],
                 e[13:12], e[11:10], e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    hp_cnt = 100; tau1_cnt = 100; tau2_cnt = 100; phi_cnt = 0;
    pulse_sync();
    cyc(3);
    run = 1'b1;
    pulse_sync();
    cyc(450);
    phi_cnt = CNT_W'(25);
    cyc(420);
    phi_cnt = CNT_W'(-25);
    cyc(420);
    phi_cnt = 0; tau1_cnt = 40;
    cyc(420);
    tau1_cnt = 0;
    cyc(420);
    hp_cnt = 1; tau1_cnt = 500; phi_cnt = CNT_W'(300);
    cyc(240);
    hp_cnt = 100; tau1_cnt = 100; tau2_cnt = 60; phi_cnt = CNT_W'(-99);
    cyc(10);
    pulse_sync();
    cyc(50);
    run = 1'b0;
    cyc(260);
    run = 1'b1;
    pulse_sync();
    cyc(77);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(5);
    for (int r = 0; r < 32; r++) begin
      int h, mode;
      h    = int'($urandom_range(0, 24));
      mode = r % 4;
      hp_cnt   = CNT_W'(h);
      tau1_cnt = CNT_W'($urandom_range(0, h + 3));
      tau2_cnt = CNT_W'($urandom_range(0, h + 3));
      phi_cnt  = CNT_W'(int'($urandom_range(0, 2 * h + 6)) - (h + 3));
      run = 1'b1;
      if (!busy) pulse_sync();
      for (int k = 0; k < 90; k++) begin
        @(negedge clk);
        rst = (mode == 3) && (k == 40);
        if (mode == 1 && k == 30) run = 1'b0;
        if (mode == 2) begin
          run  = $urandom_range(0, 3) != 0;
          sync = $urandom_range(0, 7) == 0;
        end
        if (k == 45) phi_cnt = CNT_W'(int'($urandom_range(0, 2 * h + 6)) - (h + 3));
      end
      sync = 1'b0;
      rst  = 1'b0;
    end
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
